// File: rtl/mpmc10_pkg.sv
// Shared encodings for the mpmc10 controller state machines and their monitors.
package mpmc10_pkg;

    localparam int unsigned IDLE           = 0;
    localparam int unsigned MPMC10_STATE_W = 4;

endpackage

// File: rtl/mpmc10_hist_shift.sv
// DEPTH-entry shift register of departed states; entry 0 is the newest, cnt saturates at DEPTH.
module mpmc10_hist_shift #(
    parameter int unsigned W     = 4,
    parameter int unsigned DEPTH = 4,
    parameter logic [W-1:0] FILL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         shift,
    input  logic [W-1:0]                 din,
    output logic [DEPTH*W-1:0]           q,
    output logic [$clog2(DEPTH+1)-1:0]   cnt
);

    localparam int unsigned CNTW = $clog2(DEPTH + 1);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q   <= {DEPTH{FILL}};
            cnt <= '0;
        end else if (shift) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                q[i*W +: W] <= q[(i-1)*W +: W];
            end
            q[W-1:0] <= din;
            if (cnt != CNTW'(DEPTH)) begin
                cnt <= cnt + CNTW'(1);
            end
        end
    end

endmodule

// File: rtl/mpmc10_state_monitor.sv
// State-history and stuck-state watchdog placed beside an mpmc10 state machine.
module mpmc10_state_monitor
    import mpmc10_pkg::*;
#(
    parameter int unsigned  SW      = MPMC10_STATE_W,
    parameter int unsigned  DEPTH   = 4,
    parameter int unsigned  CW      = 16,
    parameter int unsigned  TIMEOUT = 1023,
    parameter logic [SW-1:0] IDLE_ST = SW'(IDLE)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [SW-1:0]                state,
    input  logic                         clr,
    output logic [SW-1:0]                cur_state,
    output logic [SW-1:0]                prev_state,
    output logic                         state_chg,
    output logic [DEPTH*SW-1:0]          hist,
    output logic [$clog2(DEPTH+1)-1:0]   hist_cnt,
    output logic [CW-1:0]                dwell,
    output logic [CW-1:0]                trans_cnt,
    output logic                         timeout,
    output logic [SW-1:0]                timeout_state
);

    logic chg;
    logic stall;

    assign chg   = (state != cur_state);
    assign stall = !chg && (cur_state != IDLE_ST) && (dwell == CW'(TIMEOUT - 1));

    mpmc10_hist_shift #(
        .W     (SW),
        .DEPTH (DEPTH),
        .FILL  (IDLE_ST)
    ) u_hist (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .shift (chg),
        .din   (cur_state),
        .q     (hist),
        .cnt   (hist_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state     <= IDLE_ST;
            prev_state    <= IDLE_ST;
            state_chg     <= 1'b0;
            dwell         <= '0;
            trans_cnt     <= '0;
            timeout       <= 1'b0;
            timeout_state <= IDLE_ST;
        end else begin
            cur_state <= state;
            state_chg <= chg;
            // The legacy idle/changed/hold rule always resolves to the incoming state.
            prev_state <= state;

            if (chg) begin
                dwell <= '0;
            end else if (dwell != {CW{1'b1}}) begin
                dwell <= dwell + CW'(1);
            end

            if (clr) begin
                trans_cnt <= '0;
            end else if (chg) begin
                trans_cnt <= trans_cnt + CW'(1);
            end

            if (clr) begin
                timeout       <= 1'b0;
                timeout_state <= IDLE_ST;
            end else if (!timeout && stall) begin
                timeout       <= 1'b1;
                timeout_state <= cur_state;
            end
        end
    end

endmodule

// File: tb/tb_mpmc10_state_monitor.sv
// Directed self-checking bench for mpmc10_state_monitor (main instance plus a CW=4 saturation instance).
module tb_mpmc10_state_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic [3:0]  state;

    logic [3:0]  cur_state, prev_state, timeout_state;
    logic        state_chg, timeout;
    logic [15:0] hist;
    logic [2:0]  hist_cnt;
    logic [15:0] dwell, trans_cnt;

    logic [3:0]  s_cur, s_prev, s_tos;
    logic        s_chg, s_to;
    logic [15:0] s_hist;
    logic [2:0]  s_hcnt;
    logic [3:0]  s_dwell, s_trans;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mpmc10_state_monitor #(
        .SW (4), .DEPTH (4), .CW (16), .TIMEOUT (8), .IDLE_ST (4'd0)
    ) dut (
        .clk (clk), .rst (rst), .state (state), .clr (clr),
        .cur_state (cur_state), .prev_state (prev_state), .state_chg (state_chg),
        .hist (hist), .hist_cnt (hist_cnt), .dwell (dwell), .trans_cnt (trans_cnt),
        .timeout (timeout), .timeout_state (timeout_state)
    );

    mpmc10_state_monitor #(
        .SW (4), .DEPTH (4), .CW (4), .TIMEOUT (8), .IDLE_ST (4'd0)
    ) dut_sat (
        .clk (clk), .rst (rst), .state (state), .clr (clr),
        .cur_state (s_cur), .prev_state (s_prev), .state_chg (s_chg),
        .hist (s_hist), .hist_cnt (s_hcnt), .dwell (s_dwell), .trans_cnt (s_trans),
        .timeout (s_to), .timeout_state (s_tos)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [3:0] s, input logic c);
        state = s;
        clr   = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit seen_to;
        logic [3:0] seq_p [5] = '{4'd0, 4'd3, 4'd3, 4'd0, 4'd7};

        rst = 1'b1; clr = 1'b0; state = 4'd5;
        step(4'd5, 1'b0);
        step(4'd5, 1'b0);
        chk("rst_cur", cur_state, 0);
        chk("rst_prev", prev_state, 0);
        chk("rst_chg", state_chg, 0);
        chk("rst_hist", hist, 0);
        chk("rst_hcnt", hist_cnt, 0);
        chk("rst_dwell", dwell, 0);
        chk("rst_trans", trans_cnt, 0);
        chk("rst_to", timeout, 0);
        chk("rst_tos", timeout_state, 0);
        rst = 1'b0;

        // History: 0,1,2,3,4,5
        step(4'd0, 1'b0);
        chk("hist_nochg", state_chg, 0);
        for (int i = 1; i <= 5; i++) begin
            step(4'(i), 1'b0);
            chk("hist_chg_pulse", state_chg, 1);
        end
        chk("hist_entries", hist, 16'h1234);
        chk("hist_cnt", hist_cnt, 4);
        chk("hist_trans", trans_cnt, 5);
        chk("hist_cur", cur_state, 5);
        step(4'd5, 1'b0);
        chk("hist_chg_drop", state_chg, 0);
        chk("hist_dwell1", dwell, 1);

        // Legacy prev_state
        for (int i = 0; i < 5; i++) begin
            step(seq_p[i], 1'b0);
            chk("prev_state", prev_state, 32'(seq_p[i]));
        end

        // Timeout at TIMEOUT=8
        step(4'd0, 1'b1);
        for (int i = 0; i < 8; i++) step(4'd5, 1'b0);
        chk("to_early", timeout, 0);
        chk("to_dwell7", dwell, 7);
        step(4'd5, 1'b0);
        chk("to_rise", timeout, 1);
        chk("to_state", timeout_state, 5);
        for (int i = 0; i < 20; i++) step(4'd6, 1'b0);
        chk("to_frozen", timeout_state, 5);
        chk("to_hold", timeout, 1);
        chk("to_dwell6", dwell, 19);

        // IDLE never times out
        step(4'd0, 1'b1);
        chk("clr_to", timeout, 0);
        seen_to = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step(4'd0, 1'b0);
            if (timeout) seen_to = 1'b1;
        end
        chk("idle_no_to", 32'(seen_to), 0);
        chk("idle_dwell", dwell, 100);

        // clr together with a change 2->4
        step(4'd2, 1'b0);
        step(4'd4, 1'b1);
        chk("clrchg_hist", hist, 0);
        chk("clrchg_hcnt", hist_cnt, 0);
        chk("clrchg_trans", trans_cnt, 0);
        chk("clrchg_cur", cur_state, 4);
        chk("clrchg_pulse", state_chg, 1);

        // clr on the edge timeout would rise
        for (int i = 0; i < 7; i++) step(4'd4, 1'b0);
        chk("clrto_dwell", dwell, 7);
        step(4'd4, 1'b1);
        chk("clrto_to", timeout, 0);
        step(4'd4, 1'b0);
        chk("clrto_after", timeout, 0);

        // Saturation on the CW=4 instance
        step(4'd0, 1'b0);
        for (int i = 0; i < 20; i++) step(4'd0, 1'b0);
        chk("sat_dwell", s_dwell, 15);
        step(4'd0, 1'b0);
        chk("sat_dwell_hold", s_dwell, 15);
        step(4'd0, 1'b1);
        for (int i = 0; i < 17; i++) step((i % 2 == 0) ? 4'd1 : 4'd0, 1'b0);
        chk("sat_trans_wrap", s_trans, 1);
        chk("main_trans17", trans_cnt, 17);

        // Mid-operation reset beats clr
        rst = 1'b1;
        step(4'd9, 1'b1);
        chk("rst2_cur", cur_state, 0);
        chk("rst2_hcnt", hist_cnt, 0);
        chk("rst2_trans", trans_cnt, 0);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mpmc10_state_monitor.md
# mpmc10_state_monitor

Parametrised state-history and watchdog monitor for the mpmc10 controller state machines. It generalises the single previous-state register into several pieces of observation state: a DEPTH-entry transition history, a per-state dwell counter, a transition counter, and a sticky stuck-state timeout. It sits beside each mpmc10 state machine, and its outputs feed the controller's recovery logic and the debug/status registers.

## Interface
Parameters:
- SW, 4: state width in bits.
- DEPTH, 4: number of history entries; must be at least 1.
- CW, 16: width of the dwell and transition counters.
- TIMEOUT, 1023: dwell count that flags a stuck non-idle state. Requires 1 ≤ TIMEOUT < 2^CW.
- IDLE_ST, mpmc10_pkg::IDLE: the idle state encoding, widened or truncated to SW bits.

Ports:
- clk, input, 1: the single clock.
- rst, input, 1: reset, synchronous and active-high.
- state, input, SW: current state of the monitored state machine.
- clr, input, 1: synchronous clear of history, counters and timeout.
- cur_state, output, SW: registered copy of state.
- prev_state, output, SW: legacy previous-state output.
- state_chg, output, 1: one-cycle pulse on each state change.
- hist, output, DEPTH*SW: states most recently left. Entry 0 occupies bits [SW-1:0] and is the newest.
- hist_cnt, output, $clog2(DEPTH+1): number of valid history entries, saturating at DEPTH.
- dwell, output, CW: edges spent in cur_state since entering it, saturating.
- trans_cnt, output, CW: total state changes, wrapping.
- timeout, output, 1: sticky stuck-state flag.
- timeout_state, output, SW: the state that caused timeout.

## Operation
- Change detect: chg = (state != cur_state), evaluated on every edge.
- On chg:
  - cur_state <= state, dwell <= 0, state_chg <= 1, trans_cnt <= trans_cnt+1 (wraps at 2^CW).
  - hist shifts up one entry and entry 0 <= old cur_state; the oldest entry is discarded.
  - hist_cnt <= min(hist_cnt+1, DEPTH).
- No chg: state_chg <= 0, dwell <= dwell+1, saturating at 2^CW-1.
- prev_state (legacy rule):
  - If state==IDLE_ST: prev_state <= IDLE_ST.
  - Else if state != prev_state: prev_state <= state.
  - Otherwise hold. The IDLE state may be held indefinitely.
- Timeout:
  - Condition: no chg, cur_state != IDLE_ST, and dwell == TIMEOUT-1.
  - Action: timeout <= 1 and timeout_state <= cur_state.
  - While set, timeout holds and timeout_state is frozen; later stalls do not overwrite it.
  - IDLE_ST never causes a timeout.
- clr:
  - Clears hist to all IDLE_ST, hist_cnt to 0, trans_cnt to 0, timeout to 0 and timeout_state to IDLE_ST.
  - cur_state, dwell, prev_state and state_chg update normally.
  - clr and chg on the same edge: clr wins for hist, hist_cnt and trans_cnt, which all end cleared. cur_state, dwell and state_chg still take the change.
  - clr and the timeout condition on the same edge: clr wins, and timeout ends 0.
- rst has priority over everything, including clr.

## Timing
- Reset values, applied on the first edge with rst=1 (including mid-operation):
  - cur_state, prev_state, timeout_state and every hist entry = IDLE_ST.
  - hist_cnt, dwell, trans_cnt, state_chg and timeout = 0.
- Every output is a register; there is no combinational path from any input to any output.
- Latency is one edge from state to cur_state, prev_state, state_chg and hist.
- A new state entered at edge E and held reaches dwell=k at edge E+k.
- timeout rises at edge E+TIMEOUT, i.e. after the state has been presented for TIMEOUT+1 edges.
- state_chg is high for exactly one cycle per change. Back-to-back changes give consecutive pulses.

## Structure
- mpmc10_pkg holds IDLE (already present) and a new localparam MPMC10_STATE_W=4. Instantiations take SW from it.
- The history shifter is its own sub-module: mpmc10_hist_shift #(W, DEPTH), with ports clk, rst, clr, shift, din, q and cnt.
- The counters, prev_state, timeout logic and change detect live in the top module.

## Test plan
- Reset (DEPTH=4, IDLE_ST=0): drive state=5 with rst=1 for 2 edges → every output at its reset value, cur_state=0, dwell=0.
- History (DEPTH=4): step the sequence 0,1,2,3,4,5 one per edge.
  - Expected: hist entries 0..3 = 4,3,2,1, hist_cnt=4, trans_cnt=5.
  - state_chg high for 5 consecutive cycles.
- Legacy prev_state: step 0,3,3,0,7.
  - Expected: prev_state after each edge = 0,3,3,0,7.
- Timeout (TIMEOUT=8): enter state 5 and hold it.
  - After 8 edges: timeout=0, dwell=7.
  - After 9th edge: timeout=1, timeout_state=5.
  - Switch to 6 and hold 20 edges: timeout_state stays 5.
  - Hold state 0 for 100 edges from a clean start: timeout never sets.
- Clear collisions:
  - clr on the same edge as a change 2→4: hist all 0, hist_cnt=0, trans_cnt=0, cur_state=4, state_chg=1.
  - clr on the edge timeout would set: timeout stays 0.
- Saturation (CW=4): hold state 0 for 20 edges → dwell=15 and stays there. Make 17 changes → trans_cnt=1.
